// File: rtl/sm_regdump_uart.sv
// Debug register dumper: walks a range of CPU debug addresses, samples each value,
// and streams it as a 5-byte record {reg, data[31:24..7:0]} on an 8N1 UART line.
module sm_regdump_uart #(
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        uart_tx
);

    localparam int unsigned BAUD_W = $clog2(CLK_DIV);
    localparam int unsigned REC_W  = 40;

    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLK_DIV - 1);
    localparam logic [4:0]        FIRST5    = 5'(FIRST_REG);
    localparam logic [4:0]        LAST5     = 5'(LAST_REG);
    localparam logic [3:0]        STOP_BIT  = 4'd9;
    localparam logic [2:0]        LAST_BYTE = 3'd4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADDR   = 2'd1;
    localparam logic [1:0] S_SEND   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // Reject illegal parameterisations at elaboration time.
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("sm_regdump_uart: CLK_DIV must be >= 2");
    end
    if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_reg_range
        $error("sm_regdump_uart: need FIRST_REG <= LAST_REG <= 31");
    end

    logic [1:0]        state_q,    state_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              tx_q,       tx_d;
    logic [4:0]        addr_q,     addr_d;
    logic [4:0]        reg_cnt_q,  reg_cnt_d;
    logic [REC_W-1:0]  buf_q,      buf_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [3:0]        bit_idx_q,  bit_idx_d;
    logic [BAUD_W-1:0] baud_q,     baud_d;
    logic [7:0]        cur_byte_c;

    // The byte on the wire is always the top byte of the record buffer.
    assign cur_byte_c = buf_q[REC_W-1 -: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
            addr_q     <= FIRST5;
            reg_cnt_q  <= '0;
            buf_q      <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            reg_cnt_q  <= reg_cnt_d;
            buf_q      <= buf_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
        end
    end

    // Next-state logic; tx_d is the bit value the line carries in the following cycle.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_d       = tx_q;
        addr_d     = addr_q;
        reg_cnt_d  = reg_cnt_q;
        buf_d      = buf_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;

        case (state_q)
            S_IDLE: begin
                addr_d = FIRST5;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d   = S_ADDR;
                    reg_cnt_d = FIRST5;
                    addr_d    = FIRST5;
                    busy_d    = 1'b1;
                end
            end

            S_ADDR: begin
                buf_d      = {3'b000, reg_cnt_q, regData};
                byte_idx_d = '0;
                bit_idx_d  = '0;
                baud_d     = '0;
                tx_d       = 1'b0;
                state_d    = S_SEND;
            end

            S_SEND: begin
                if (baud_q == LAST_BAUD) begin
                    baud_d = '0;
                    if (bit_idx_q == STOP_BIT) begin
                        if (byte_idx_q == LAST_BYTE) begin
                            tx_d = 1'b1;
                            if (reg_cnt_q == LAST5) begin
                                state_d = S_FINISH;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                reg_cnt_d = reg_cnt_q + 5'd1;
                                addr_d    = reg_cnt_q + 5'd1;
                                state_d   = S_ADDR;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 3'd1;
                            bit_idx_d  = '0;
                            buf_d      = {buf_q[REC_W-9:0], 8'h00};
                            tx_d       = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte_c[bit_idx_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                addr_d  = FIRST5;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign uart_tx = tx_q;
    assign regAddr = addr_q;

endmodule
